// File: rtl/apb_regbank_slave.sv
// APB completer: NUM_REGS R/W words plus a read-only status word, WAIT_CYCLES wait states, PSLVERR on bad access.
// Optional build macro APB_SLV_PROT_CHECK_EN rejects unprivileged (pprot[0]=0) accesses.
module apb_regbank_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   hclk,
    input  logic                   hrstn,
    input  logic                   pclk_en,
    input  logic                   psel,
    input  logic                   penable,
    input  logic [ADDRWIDTH-1:0]   paddr,
    input  logic                   pwrite,
    input  logic [3:0]             pstrb,
    input  logic [2:0]             pprot,
    input  logic [31:0]            pwdata,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [31:0]            stat_in,
    output logic [NUM_REGS*32-1:0] regs_out
);

    localparam int IDXW = ADDRWIDTH - 2;
    localparam logic [IDXW-1:0] STAT_IDX = IDXW'(NUM_REGS);
    localparam logic [3:0]      WAIT_LD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t         state, state_nxt;
    logic [3:0]     wcnt, wcnt_nxt;
    logic [31:0]    regs [NUM_REGS];
    logic [IDXW-1:0] idx;
    logic           prot_err;
    logic           err;
    logic           commit;
    logic [31:0]    rd_word;
    logic           unused_bits;

    assign idx         = paddr[ADDRWIDTH-1:2];
    assign unused_bits = ^{paddr[1:0], pprot};

`ifdef APB_SLV_PROT_CHECK_EN
    assign prot_err = ~pprot[0];
`else
    assign prot_err = 1'b0;
`endif

    // Status word is read-only; anything past it is unmapped.
    assign err    = prot_err | (idx > STAT_IDX) | ((idx == STAT_IDX) & pwrite);
    assign commit = pclk_en & (state == ST_READY) & psel & penable & pwrite & ~err;

    always_comb begin
        rd_word = '0;
        if (idx == STAT_IDX) rd_word = stat_in;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDXW'(i)) rd_word = regs[i];
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_READY;
                    end else begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel)              state_nxt = ST_IDLE;
                else if (wcnt == 4'd1)  state_nxt = ST_READY;
                else                    wcnt_nxt  = wcnt - 4'd1;
            end
            ST_READY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else if (pclk_en) begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IDXW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (pstrb[b]) regs[i][8*b +: 8] <= pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign pready  = (state == ST_READY);
    assign pslverr = pready & err;
    assign prdata  = (pready && !pwrite && !err) ? rd_word : 32'd0;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_out
            assign regs_out[32*g +: 32] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench: zero-wait instance u0 for data paths and errors, three-wait instance u3 for wait states and abort.
module tb_apb_regbank_slave;

    logic         hclk = 1'b0;
    logic         hrstn;
    logic         pclk_en;
    logic         psel0, psel1;
    logic         penable;
    logic [15:0]  paddr;
    logic         pwrite;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic [31:0]  pwdata;
    logic [31:0]  stat_in;

    logic [31:0]  prdata0, prdata1;
    logic         pready0, pready1;
    logic         pslverr0, pslverr1;
    logic [255:0] regs_out0, regs_out1;

    logic [31:0]  cap_rd;
    logic         cap_err;
    logic         cap_rdy;
    logic [255:0] snap;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    apb_regbank_slave #(.ADDRWIDTH(16), .NUM_REGS(8), .WAIT_CYCLES(0)) u0 (
        .hclk(hclk), .hrstn(hrstn), .pclk_en(pclk_en), .psel(psel0), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .stat_in(stat_in),
        .regs_out(regs_out0)
    );

    apb_regbank_slave #(.ADDRWIDTH(16), .NUM_REGS(8), .WAIT_CYCLES(3)) u3 (
        .hclk(hclk), .hrstn(hrstn), .pclk_en(pclk_en), .psel(psel1), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .stat_in(stat_in),
        .regs_out(regs_out1)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete zero-wait transfer on u0; outputs captured mid access phase.
    task automatic apb0(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] pr);
        psel0 = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = d; pstrb = s; pprot = pr;
        tick();
        penable = 1'b1;
        #1;
        cap_rdy = pready0;
        cap_err = pslverr0;
        cap_rd  = prdata0;
        tick();
        psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        hrstn = 1'b0; pclk_en = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pstrb = '0; pprot = 3'b001; pwdata = '0;
        stat_in = 32'h0;
        #12;
        chk("rst_pready",   {255'd0, pready0},  256'd0);
        chk("rst_pslverr",  {255'd0, pslverr0}, 256'd0);
        chk("rst_prdata",   {224'd0, prdata0},  256'd0);
        chk("rst_regs",     regs_out0,          256'd0);
        chk("rst_pready3",  {255'd0, pready1},  256'd0);
        hrstn = 1'b1;
        tick();

        // Zero-wait write, then read back
        apb0(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b001);
        chk("wr_pready",  {255'd0, cap_rdy}, 256'd1);
        chk("wr_pslverr", {255'd0, cap_err}, 256'd0);
        chk("wr_reg1",    {224'd0, regs_out0[63:32]}, {224'd0, 32'hDEADBEEF});
        apb0(1'b0, 16'h0004, 32'h0, 4'h0, 3'b001);
        chk("rd_reg1",    {224'd0, cap_rd},  {224'd0, 32'hDEADBEEF});
        chk("rd_pslverr", {255'd0, cap_err}, 256'd0);
        chk("idle_prdata", {224'd0, prdata0}, 256'd0);

        // Byte strobes, issued back-to-back
        apb0(1'b1, 16'h0008, 32'h11223344, 4'hF, 3'b001);
        apb0(1'b1, 16'h0008, 32'hAABBCCDD, 4'b0101, 3'b001);
        chk("strb_reg2", {224'd0, regs_out0[95:64]}, {224'd0, 32'h11BB33DD});

        // Error paths
        snap = regs_out0;
        stat_in = 32'h0000_1234;
        apb0(1'b1, 16'h0020, 32'h5555AAAA, 4'hF, 3'b001);
        chk("stat_wr_err",  {255'd0, cap_err}, 256'd1);
        chk("stat_wr_regs", regs_out0, snap);
        apb0(1'b0, 16'h0024, 32'h0, 4'h0, 3'b001);
        chk("oob_rd_err",  {255'd0, cap_err}, 256'd1);
        chk("oob_rd_data", {224'd0, cap_rd},  256'd0);
        stat_in = 32'hCAFE0001;
        apb0(1'b0, 16'h0020, 32'h0, 4'h0, 3'b001);
        chk("stat_rd_data", {224'd0, cap_rd},  {224'd0, 32'hCAFE0001});
        chk("stat_rd_err",  {255'd0, cap_err}, 256'd0);

        // Privilege check
        snap = regs_out0;
`ifdef APB_SLV_PROT_CHECK_EN
        apb0(1'b1, 16'h0014, 32'h0BADF00D, 4'hF, 3'b000);
        chk("prot0_err",  {255'd0, cap_err}, 256'd1);
        chk("prot0_regs", regs_out0, snap);
        apb0(1'b1, 16'h0014, 32'h0BADF00D, 4'hF, 3'b001);
        chk("prot1_err",  {255'd0, cap_err}, 256'd0);
        chk("prot1_reg5", {224'd0, regs_out0[191:160]}, {224'd0, 32'h0BADF00D});
`else
        apb0(1'b1, 16'h0014, 32'h0BADF00D, 4'hF, 3'b000);
        chk("noprot_err",  {255'd0, cap_err}, 256'd0);
        chk("noprot_reg5", {224'd0, regs_out0[191:160]}, {224'd0, 32'h0BADF00D});
`endif

        // Wait states on u3 with pclk_en alternating
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004;
        pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001; pclk_en = 1'b1;
        tick();
        penable = 1'b1;
        for (int j = 0; j < 8; j++) begin
            pclk_en = j[0];
            tick();
            chk($sformatf("wait_pready_%0d", j), {255'd0, pready1},
                {255'd0, (j == 5 || j == 6)});
            if (j == 6) chk("wait_nocommit_dis", {224'd0, regs_out1[63:32]}, 256'd0);
        end
        chk("wait_commit", {224'd0, regs_out1[63:32]}, {224'd0, 32'h5A5A5A5A});
        psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0; pclk_en = 1'b1;
        tick();

        // Abort during the wait phase on u3
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        psel1 = 1'b0; penable = 1'b0;
        tick();
        chk("abort_pready", {255'd0, pready1}, 256'd0);
        tick(); tick(); tick();
        chk("abort_pready_late", {255'd0, pready1}, 256'd0);
        chk("abort_reg2", {224'd0, regs_out1[95:64]}, 256'd0);
        pwrite = 1'b0;

        // Reset pulse during the ready phase of a u0 write
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004;
        pwdata = 32'h12345678; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        #1;
        chk("pre_rst_pready", {255'd0, pready0}, 256'd1);
        hrstn = 1'b0;
        #1;
        chk("rst_mid_pready", {255'd0, pready0}, 256'd0);
        chk("rst_mid_regs",   regs_out0, 256'd0);
        tick();
        hrstn = 1'b1;
        psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tick();
        chk("post_rst_pready", {255'd0, pready0}, 256'd0);
        chk("post_rst_reg1",   {224'd0, regs_out0[63:32]}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
